// File: rtl/shift_mult_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package shift_mult_pkg;

  localparam int unsigned SHIFT_MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/shift_add_step.sv
// One add-and-shift-right step of the multiplier: conditionally add mcand into hi,
// then shift the {carry, sum, lo} word right by one.
module shift_add_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});
    hi_next = sum[WIDTH:1];
    lo_next = {sum[0], lo[WIDTH-1:1]};
  end

endmodule

// File: rtl/shift_mult.sv
// Sequential shift-and-add multiplier with valid/ready handshakes; signed mode works on
// magnitudes and applies the sign in a single correction cycle.
module shift_mult
  import shift_mult_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_MULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   step_hi, step_lo;

  // Magnitude stays WIDTH bits unsigned, so the most negative value maps exactly.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  shift_add_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .hi     (hi_q),
    .lo     (lo_q),
    .mcand  (mcand_q),
    .hi_next(step_hi),
    .lo_next(step_lo)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d = magnitude(a, is_signed);
          lo_d    = magnitude(b, is_signed);
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          hi_d    = '0;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        hi_d    = step_hi;
        lo_d    = step_lo;
        count_d = count_q + CntW'(1);
        if (count_q == LastStep) state_d = StFix;
      end
      StFix: begin
        product_d = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        state_d   = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  // Gate with reset so the unit never advertises readiness while held in reset.
  assign in_ready  = (state_q == StIdle) & ~reset;
  assign out_valid = (state_q == StDone);
  assign product   = product_q;

endmodule

// File: doc/shift_mult.md
# shift_mult

Sequential shift-and-add multiplier that sits directly downstream of the combinational `shift` unit in the Lab2 datapath. It accepts two WIDTH-bit operands, runs one add-and-shift-right step per clock, and returns a 2·WIDTH-bit product. It supports unsigned and two's-complement signed modes and uses valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 32, operand width; product is 2·WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; one clock domain.
- `in_valid`  in  1  operands and mode valid.
- `in_ready`  out  1  unit idle, can accept.
- `a`  in  WIDTH  multiplicand.
- `b`  in  WIDTH  multiplier.
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned.
- `out_valid`  out  1  `product` valid.
- `out_ready`  in  1  consumer takes `product`.
- `product`  out  2·WIDTH  result.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: WIDTH steps.
  - FIX: sign correction, 1 cycle.
  - DONE: `out_valid`=1.
- Accept happens on an edge with `in_valid && in_ready`. At that edge the block:
  - latches `mcand` = |a| and `lo` = |b| (magnitudes only when `is_signed`; else raw);
  - sets `neg` = is_signed & (a[W-1] ^ b[W-1]);
  - sets `hi`=0 and `count`=0;
  - moves IDLE→RUN.
- Magnitudes are WIDTH-bit unsigned, so |−2^(W−1)| = 2^(W−1) is exact.
- RUN step, each edge:
  - {c, s} = hi + (lo[0] ? mcand : 0), computed WIDTH+1 bits wide;
  - {hi, lo} ← {c, s, lo} >> 1;
  - count++.
  - After the WIDTH-th step the block goes RUN→FIX.
- FIX:
  - `product` ← neg ? −{hi,lo} : {hi,lo}, modulo 2^(2W);
  - `out_valid` ← 1;
  - FIX→DONE.
- DONE:
  - `product` and `out_valid` are held stable while `out_ready`=0.
  - On an edge with `out_ready`=1, `out_valid`←0 and DONE→IDLE.
- `in_ready` is low in RUN, FIX and DONE. `in_valid` is ignored there, with no queuing.
- A new operation cannot be accepted on the same edge as the output handoff.
- Operands may change after acceptance; internal copies are used.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - state=IDLE;
  - `product`=0, `out_valid`=0;
  - hi, lo, mcand, count, neg = 0.
- `in_ready`=0 while `reset` is high and 1 in the first cycle after release.
- Latency: accept edge E0, steps E1..E_W, FIX at E_(W+1). `out_valid` is high after E_(W+1), i.e. 33 edges for WIDTH=32, independent of operand values or mode.
- Minimum throughput is one operation per W+3 cycles (accept, W steps, FIX, handoff, return to IDLE).
- `product` changes only at the FIX edge or at reset. It is not cleared on handoff.
- Reset mid-operation, in RUN, FIX or DONE: the operation is discarded, all outputs return to reset values immediately, and no `out_valid` pulse is emitted.
- `count` is ⌈log2(WIDTH+1)⌉ bits and never wraps within an operation.

## Structure
- Package `shift_mult_pkg` holds:
  - state enum {IDLE, RUN, FIX, DONE};
  - `SHIFT_MULT_WIDTH` = 32 default.
- One combinational sub-module, `shift_add_step`:
  - inputs: hi, lo, mcand;
  - outputs: next hi, next lo.
  - Keeping it separate lets it be unit-checked in isolation.
- FSM, counter and handshake logic live in `shift_mult`.

## Test plan
- Unsigned 3×5:
  - product = 0x000000000000000F;
  - `out_valid` rises exactly 33 edges after accept;
  - `in_ready` is low throughout.
- Unsigned 0xFFFFFFFF×0xFFFFFFFF: product = 0xFFFFFFFE00000001.
- Signed cases:
  - 0xFFFFFFFF(−1)×2 → 0xFFFFFFFFFFFFFFFE;
  - 0x80000000×0x80000000 → 0x4000000000000000;
  - 7×0 → 0.
- Backpressure:
  - hold `out_ready`=0 for 10 cycles after `out_valid` → `product` is stable and `in_ready`=0;
  - raise `out_ready` for one cycle → `out_valid` falls and `in_ready`=1 next cycle.
- Busy input: toggle `in_valid` with new operands during RUN → ignored, result equals the first operation.
- Reset mid-run: assert `reset` at step 16 → `out_valid`=0 and `product`=0 immediately. After release, `in_ready`=1, and a new 2×2 → 4 after 33 edges.
